// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and widths for the instruction fetch queue.
// Holds the entry payload stored per queued instruction.
package inst_fetch_queue_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } InstQueueEntry;

  // Counter width able to represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/inst_fetch_queue_mem.sv
// Entry storage for the fetch queue: one write port, one asynchronous read port,
// contents cleared synchronously on reset so the read port never shows X.
module inst_fetch_queue_mem
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  InstQueueEntry i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output InstQueueEntry o_rd_data_c
);

  InstQueueEntry r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction buffer between fetch and decode; strict FIFO, emptied in one cycle on flush.
// INST_FETCH_QUEUE_BYPASS_EN: forwards in_* straight to out_* when the queue is empty.
module inst_fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = inst_fetch_queue_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = inst_fetch_queue_pkg::DATA_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_in_valid,
  input  logic [ADDR_WIDTH-1:0]        i_in_pc,
  input  logic [DATA_WIDTH-1:0]        i_in_data,
  output logic                         o_in_ready,
  output logic                         o_out_valid,
  output logic [ADDR_WIDTH-1:0]        o_out_pc,
  output logic [DATA_WIDTH-1:0]        o_out_data,
  input  logic                         i_out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

  import inst_fetch_queue_pkg::*;

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = cnt_width(DEPTH);
  localparam int unsigned ENT_AW = inst_fetch_queue_pkg::ADDR_WIDTH;
  localparam int unsigned ENT_DW = inst_fetch_queue_pkg::DATA_WIDTH;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_in_ready;

  logic             w_kill;
  logic             w_stored_valid;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;
  InstQueueEntry    w_wr_entry;
  InstQueueEntry    w_rd_entry;

  // Reset behaves exactly like a flush for the control path.
  assign w_kill         = i_rst | i_flush;
  assign w_stored_valid = (r_count != '0) & ~w_kill;

`ifdef INST_FETCH_QUEUE_BYPASS_EN
  assign w_bypass = (r_count == '0) & i_in_valid & ~w_kill;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed instruction taken by decode this cycle is never written.
  assign w_push = i_in_valid & r_in_ready & ~w_kill & ~(w_bypass & i_out_ready);
  assign w_pop  = w_stored_valid & i_out_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_kill) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (w_kill) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != CNT_W'(DEPTH));
    end
  end

  assign w_wr_entry = '{pc: ENT_AW'(i_in_pc), data: ENT_DW'(i_in_data)};

  inst_fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_en     (w_push),
    .i_wr_addr   (r_wr_ptr),
    .i_wr_data   (w_wr_entry),
    .i_rd_addr   (r_rd_ptr),
    .o_rd_data_c (w_rd_entry)
  );

  assign o_in_ready  = r_in_ready;
  assign o_occupancy = r_count;
  assign o_out_valid = w_stored_valid | w_bypass;

`ifdef INST_FETCH_QUEUE_BYPASS_EN
  assign o_out_pc   = w_bypass ? i_in_pc   : ADDR_WIDTH'(w_rd_entry.pc);
  assign o_out_data = w_bypass ? i_in_data : DATA_WIDTH'(w_rd_entry.data);
`else
  assign o_out_pc   = ADDR_WIDTH'(w_rd_entry.pc);
  assign o_out_data = DATA_WIDTH'(w_rd_entry.data);
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed stimulus pushes expected entries,
// a negedge monitor pops and compares whatever decode consumes.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] XMASK = 32'hA5A5A5A5;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_flush;
  logic          i_in_valid;
  logic [31:0]   i_in_pc;
  logic [31:0]   i_in_data;
  logic          o_in_ready;
  logic          o_out_valid;
  logic [31:0]   o_out_pc;
  logic [31:0]   o_out_data;
  logic          i_out_ready;
  logic [CW-1:0] o_occupancy;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_count  = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_flush     (i_flush),
    .i_in_valid  (i_in_valid),
    .i_in_pc     (i_in_pc),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .o_out_valid (o_out_valid),
    .o_out_pc    (o_out_pc),
    .o_out_data  (o_out_data),
    .i_out_ready (i_out_ready),
    .o_occupancy (o_occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One cycle of stimulus; the reference model updates as the cycle is issued.
  task automatic drive(input logic v, input logic [31:0] pc, input logic ordy,
                       input logic fl, input logic rs);
    int   cnt_now;
    logic exp_valid;
    logic push_ok;
    logic pop_ok;
    exp_t e;
    i_in_valid  = v;
    i_in_pc     = pc;
    i_in_data   = pc ^ XMASK;
    i_out_ready = ordy;
    i_flush     = fl;
    i_rst       = rs;
    cnt_now     = m_count;
    e.pc        = pc;
    e.data      = pc ^ XMASK;
    exp_valid   = !rs && !fl && (cnt_now != 0 || (BYP && v));
    if (rs || fl) begin
      q_exp.delete();
      m_count = 0;
    end else begin
      push_ok = v && (cnt_now != int'(DEPTH));
      pop_ok  = ordy && exp_valid;
      if (push_ok) q_exp.push_back(e);
      if (BYP && cnt_now == 0 && v && ordy) m_count = 0;
      else m_count = cnt_now + int'(push_ok) - int'(pop_ok);
    end
    #2;
    chk("occupancy", 32'(o_occupancy), 32'(cnt_now));
    chk("in_ready", 32'(o_in_ready), 32'(cnt_now != int'(DEPTH)));
    chk("out_valid", 32'(o_out_valid), 32'(exp_valid));
    if (exp_valid && q_exp.size() > 0) chk("head_pc", o_out_pc, q_exp[0].pc);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed head must be the oldest outstanding expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_out_valid === 1'b1 && i_out_ready === 1'b1) begin
        if (q_exp.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got pc %h expected no output", o_out_pc);
        end else begin
          e = q_exp.pop_front();
          chk("out_pc", o_out_pc, e.pc);
          chk("out_data", o_out_data, e.data);
        end
      end
    end
  end

  initial begin
    i_rst       = 1'b1;
    i_flush     = 1'b0;
    i_in_valid  = 1'b0;
    i_in_pc     = '0;
    i_in_data   = '0;
    i_out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset_out_pc", o_out_pc, 32'h0);
    chk("reset_out_data", o_out_data, 32'h0);

    // Fill to DEPTH, fifth push held until a pop frees a slot
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h110, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Sustained push+pop across several pointer wraps
    drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3 * int'(DEPTH); i++) drive(1'b1, 32'h408 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with occupancy 3 and a simultaneous push and pop
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Fetch-to-decode latency from an empty queue
    drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream with two entries held
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    i_rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(o_out_valid), 32'h0);
    chk("post_rst_pc", o_out_pc, 32'h0);
    chk("post_rst_data", o_out_data, 32'h0);
    chk("post_rst_occupancy", 32'(o_occupancy), 32'h0);
    chk("post_rst_in_ready", 32'(o_in_ready), 32'h1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    chk("leftover_expected", 32'(q_exp.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
